// File: rtl/regfile_hilo_sb.sv
// regfile_hilo_sb: GPR file plus HI/LO pair with write-through bypass,
// an independent dual HI/LO write port and a per-register pending scoreboard.
// Decode reads operands and pending status and marks producers in flight.
// Writeback writes results and retires the pending marks.
module regfile_hilo_sb #(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DATA_W-1:0] wd,

    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              rd1_pend,
    output logic              rd2_pend,

    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] hi_wd,
    input  logic [DATA_W-1:0] lo_wd,
    output logic [DATA_W-1:0] hi_rd,
    output logic [DATA_W-1:0] lo_rd,

    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              sb_hilo_set,
    output logic              hilo_pend
);

    localparam int NREG = 2 ** AW;

    // Architectural state and its next-state values.
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic              hilo_pend_q, hilo_pend_d;

    // Qualified write strobes: r0 is hardwired, so writes and marks to it vanish.
    logic gpr_wr;
    logic sb_wr;
    logic hilo_wr;

    assign gpr_wr  = we && (wa != '0);
    assign sb_wr   = sb_set && (sb_addr != '0);
    assign hilo_wr = hi_we || lo_we;

    // Next-state for the GPR array; r0 is forced to zero every cycle.
    always_comb begin
        rf_d = rf_q;
        if (gpr_wr) begin
            rf_d[wa] = wd;
        end
        rf_d[0] = '0;
    end

    // Next-state for HI and LO; the two ports are independent.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (hi_we) begin
            hi_d = hi_wd;
        end
        if (lo_we) begin
            lo_d = lo_wd;
        end
    end

    // Next-state for the GPR scoreboard; a new producer overrides a retiring one.
    always_comb begin
        pend_d = pend_q;
        if (gpr_wr) begin
            pend_d[wa] = 1'b0;
        end
        if (sb_wr) begin
            pend_d[sb_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Next-state for the HI/LO pending bit; set wins over a same-cycle write.
    always_comb begin
        hilo_pend_d = hilo_pend_q;
        if (hilo_wr) begin
            hilo_pend_d = 1'b0;
        end
        if (sb_hilo_set) begin
            hilo_pend_d = 1'b1;
        end
    end

    // State registers with synchronous reset taking priority over all updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            hi_q        <= '0;
            lo_q        <= '0;
            pend_q      <= '0;
            hilo_pend_q <= 1'b0;
        end else begin
            rf_q        <= rf_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pend_q      <= pend_d;
            hilo_pend_q <= hilo_pend_d;
        end
    end

    // GPR read ports: r0 reads zero, a same-cycle write is forwarded.
    always_comb begin
        rd1 = rf_q[ra1];
        rd2 = rf_q[ra2];
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
    end

    // Pending outputs: a register being written this cycle is already resolved.
    always_comb begin
        rd1_pend = pend_q[ra1] & ~(we && (wa == ra1));
        rd2_pend = pend_q[ra2] & ~(we && (wa == ra2));
    end

    // HI/LO read ports and pending status, each bypassed by its own write port.
    always_comb begin
        hi_rd     = hi_we ? hi_wd : hi_q;
        lo_rd     = lo_we ? lo_wd : lo_q;
        hilo_pend = hilo_pend_q & ~hilo_wr;
    end

endmodule

// File: tb/tb_regfile_hilo_sb.sv
// Directed bench for regfile_hilo_sb: reset, bypass, r0, HI/LO, scoreboards.
module tb_regfile_hilo_sb;

    localparam int DATA_W = 32;
    localparam int AW     = 5;

    logic              clk;
    logic              rst;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] wd;
    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              rd1_pend;
    logic              rd2_pend;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] hi_wd;
    logic [DATA_W-1:0] lo_wd;
    logic [DATA_W-1:0] hi_rd;
    logic [DATA_W-1:0] lo_rd;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic              sb_hilo_set;
    logic              hilo_pend;

    int checks = 0;
    int errors = 0;

    regfile_hilo_sb #(.DATA_W(DATA_W), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .rd1_pend   (rd1_pend),
        .rd2_pend   (rd2_pend),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .hi_wd      (hi_wd),
        .lo_wd      (lo_wd),
        .hi_rd      (hi_rd),
        .lo_rd      (lo_rd),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .sb_hilo_set(sb_hilo_set),
        .hilo_pend  (hilo_pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        we          = 1'b0;
        wa          = '0;
        wd          = '0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        hi_wd       = '0;
        lo_wd       = '0;
        sb_set      = 1'b0;
        sb_addr     = '0;
        sb_hilo_set = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        we = 1'b1; wa = 5'd5; wd = 32'h1234;
        hi_we = 1'b1; hi_wd = 32'hAAAA;
        sb_set = 1'b1; sb_addr = 5'd7;
        tick();
        idle_inputs();
        ra1 = 5'd5; ra2 = 5'd7;
        #1;
        checks++;
        if (rd1 !== 32'h1234) begin
            errors++; $display("FAIL pre_reset_r5: got %h expected %h", rd1, 32'h1234);
        end
        checks++;
        if (rd2_pend !== 1'b1) begin
            errors++; $display("FAIL pre_reset_pend7: got %b expected 1", rd2_pend);
        end
        // Reset together with a write and a set: reset must win.
        rst = 1'b1;
        we = 1'b1; wa = 5'd6; wd = 32'h77;
        sb_set = 1'b1; sb_addr = 5'd6; sb_hilo_set = 1'b1;
        tick();
        idle_inputs();
        ra1 = 5'd5; ra2 = 5'd6;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++; $display("FAIL reset_r5: got %h expected 0", rd1);
        end
        checks++;
        if (rd2 !== 32'h0) begin
            errors++; $display("FAIL reset_prio_r6: got %h expected 0", rd2);
        end
        checks++;
        if (hi_rd !== 32'h0) begin
            errors++; $display("FAIL reset_hi: got %h expected 0", hi_rd);
        end
        checks++;
        if (hilo_pend !== 1'b0) begin
            errors++; $display("FAIL reset_hilo_pend: got %b expected 0", hilo_pend);
        end
        checks++;
        if (rd2_pend !== 1'b0) begin
            errors++; $display("FAIL reset_prio_pend6: got %b expected 0", rd2_pend);
        end
        ra1 = 5'd7;
        #1;
        checks++;
        if (rd1_pend !== 1'b0) begin
            errors++; $display("FAIL reset_pend7: got %b expected 0", rd1_pend);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we = 1'b1; wa = 5'd3; wd = 32'hDEADBEEF;
        ra1 = 5'd3; ra2 = 5'd3;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_rd1: got %h expected %h", rd1, 32'hDEADBEEF);
        end
        checks++;
        if (rd2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_rd2: got %h expected %h", rd2, 32'hDEADBEEF);
        end
        ra2 = 5'd4;
        #1;
        checks++;
        if (rd2 !== 32'h0) begin
            errors++; $display("FAIL bypass_other_addr: got %h expected 0", rd2);
        end
        tick();
        idle_inputs();
        ra2 = 5'd3;
        #1;
        checks++;
        if (rd1 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stored_rd1: got %h expected %h", rd1, 32'hDEADBEEF);
        end
        checks++;
        if (rd2 !== 32'hDEADBEEF) begin
            errors++; $display("FAIL stored_rd2: got %h expected %h", rd2, 32'hDEADBEEF);
        end
    endtask

    task automatic test_r0();
        idle_inputs();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
        ra1 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++; $display("FAIL r0_same_cycle: got %h expected 0", rd1);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++; $display("FAIL r0_next_cycle: got %h expected 0", rd1);
        end
        sb_set = 1'b1; sb_addr = 5'd0;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd1_pend !== 1'b0) begin
            errors++; $display("FAIL r0_pend: got %b expected 0", rd1_pend);
        end
    endtask

    task automatic test_hilo();
        idle_inputs();
        hi_we = 1'b1; lo_we = 1'b1; hi_wd = 32'h1; lo_wd = 32'h2;
        #1;
        checks++;
        if (hi_rd !== 32'h1 || lo_rd !== 32'h2) begin
            errors++; $display("FAIL hilo_dual_bypass: got hi=%h lo=%h expected hi=1 lo=2", hi_rd, lo_rd);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hi_rd !== 32'h1 || lo_rd !== 32'h2) begin
            errors++; $display("FAIL hilo_dual_stored: got hi=%h lo=%h expected hi=1 lo=2", hi_rd, lo_rd);
        end
        lo_we = 1'b1; lo_wd = 32'h9; hi_wd = 32'h5;
        #1;
        checks++;
        if (hi_rd !== 32'h1 || lo_rd !== 32'h9) begin
            errors++; $display("FAIL lo_only_bypass: got hi=%h lo=%h expected hi=1 lo=9", hi_rd, lo_rd);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hi_rd !== 32'h1 || lo_rd !== 32'h9) begin
            errors++; $display("FAIL lo_only_stored: got hi=%h lo=%h expected hi=1 lo=9", hi_rd, lo_rd);
        end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        sb_set = 1'b1; sb_addr = 5'd9;
        ra1 = 5'd8; ra2 = 5'd9;
        #1;
        checks++;
        if (rd2_pend !== 1'b0) begin
            errors++; $display("FAIL sb_set_not_visible_yet: got %b expected 0", rd2_pend);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd2_pend !== 1'b1) begin
            errors++; $display("FAIL sb_r9_pend: got %b expected 1", rd2_pend);
        end
        checks++;
        if (rd1_pend !== 1'b0) begin
            errors++; $display("FAIL sb_r8_clear: got %b expected 0", rd1_pend);
        end
        we = 1'b1; wa = 5'd9; wd = 32'h55;
        #1;
        checks++;
        if (rd2_pend !== 1'b0 || rd2 !== 32'h55) begin
            errors++; $display("FAIL sb_write_cycle: got pend=%b rd2=%h expected pend=0 rd2=55", rd2_pend, rd2);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd2_pend !== 1'b0 || rd2 !== 32'h55) begin
            errors++; $display("FAIL sb_after_write: got pend=%b rd2=%h expected pend=0 rd2=55", rd2_pend, rd2);
        end
        we = 1'b1; wa = 5'd9; wd = 32'h66;
        sb_set = 1'b1; sb_addr = 5'd9;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd2_pend !== 1'b1 || rd2 !== 32'h66) begin
            errors++; $display("FAIL sb_set_wins: got pend=%b rd2=%h expected pend=1 rd2=66", rd2_pend, rd2);
        end
    endtask

    task automatic test_hilo_pend();
        idle_inputs();
        sb_hilo_set = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hilo_pend !== 1'b1) begin
            errors++; $display("FAIL hilo_pend_set: got %b expected 1", hilo_pend);
        end
        hi_we = 1'b1; hi_wd = 32'h7;
        #1;
        checks++;
        if (hilo_pend !== 1'b0) begin
            errors++; $display("FAIL hilo_pend_bypass: got %b expected 0", hilo_pend);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hilo_pend !== 1'b0) begin
            errors++; $display("FAIL hilo_pend_cleared: got %b expected 0", hilo_pend);
        end
        sb_hilo_set = 1'b1; lo_we = 1'b1; lo_wd = 32'h3;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (hilo_pend !== 1'b1 || lo_rd !== 32'h3) begin
            errors++; $display("FAIL hilo_pend_set_wins: got pend=%b lo=%h expected pend=1 lo=3", hilo_pend, lo_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] vals [4];
        vals[0] = 32'h11111111;
        vals[1] = 32'h22222222;
        vals[2] = 32'hA5A5A5A5;
        vals[3] = 32'h80000001;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; wa = AW'(20 + i); wd = vals[i];
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            ra1 = AW'(20 + i);
            ra2 = AW'(23 - i);
            #1;
            checks++;
            if (rd1 !== vals[i] || rd2 !== vals[3 - i]) begin
                errors++;
                $display("FAIL b2b_read_%0d: got rd1=%h rd2=%h expected rd1=%h rd2=%h",
                         i, rd1, rd2, vals[i], vals[3 - i]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        ra1 = '0;
        ra2 = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_r0();
        test_hilo();
        test_scoreboard();
        test_hilo_pend();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
